// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter/sequencer.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_XFER0 = 2'd1,
      ST_XFER1 = 2'd2
   } state_e;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   localparam int unsigned LO_LANE = 0;
   localparam int unsigned HI_LANE = 1;

   function automatic logic [7:0] lane_byte(input logic [15:0] w, input int unsigned lane);
      return w[lane*8 +: 8];
   endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Requester ports A/B plus the byte-wide memory port, bundled for mem_arbiter.
interface mem_arb_if #(
   parameter int unsigned ADDR_W = 16
) ();
   logic              a_req, b_req;
   logic              a_we, b_we;
   logic              a_word, b_word;
   logic [ADDR_W-1:0] a_addr, b_addr;
   logic [15:0]       a_wdata, b_wdata;
   logic              a_ack, b_ack;
   logic [15:0]       a_rdata, b_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_din;
   logic              mem_read, mem_write;
   logic [7:0]        mem_dout;

   modport slave (
      input  a_req, b_req, a_we, b_we, a_word, b_word, a_addr, b_addr, a_wdata, b_wdata,
      input  mem_dout,
      output a_ack, b_ack, a_rdata, b_rdata, mem_addr, mem_din, mem_read, mem_write
   );

   modport master (
      output a_req, b_req, a_we, b_we, a_word, b_word, a_addr, b_addr, a_wdata, b_wdata,
      output mem_dout,
      input  a_ack, b_ack, a_rdata, b_rdata, mem_addr, mem_din, mem_read, mem_write
   );
endinterface

// File: rtl/mem_arb_rr.sv
// Combinational 2-way picker; MEM_ARB_FIXED_PRIORITY_EN makes port A always win a tie.
module mem_arb_rr
   import mem_arb_pkg::*;
(
   input  logic [1:0] eligible,
   input  logic       last_grant,
   output logic       grant
);
   always_comb begin
      grant = PORT_A;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
      grant = eligible[0] ? PORT_A : PORT_B;
`else
      if (&eligible) begin
         grant = (last_grant == PORT_A) ? PORT_B : PORT_A;
      end else begin
         grant = eligible[0] ? PORT_A : PORT_B;
      end
`endif
   end
endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter and byte sequencer for the 64 KiB main memory.
// Build option: MEM_ARB_FIXED_PRIORITY_EN (A wins every tie, no last-grant pointer).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = 16
) (
   input logic      clk,
   input logic      rst_n,
   mem_arb_if.slave bus
);
   state_e            state_q;
   logic              grant_q, we_q, word_q;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       wdata_q;
   logic [7:0]        rd_lo_q;
   logic              a_ack_q, b_ack_q;
   logic [15:0]       a_rdata_q, b_rdata_q;
   logic [1:0]        eligible;
   logic              grant;
   logic              last_grant;
   logic              done;
   logic [15:0]       rd_word;

   // A port whose ack is high this cycle is masked so it cannot be granted twice.
   assign eligible = {bus.b_req & ~b_ack_q, bus.a_req & ~a_ack_q};

`ifdef MEM_ARB_FIXED_PRIORITY_EN
   assign last_grant = PORT_B;
`else
   logic last_grant_q;
   assign last_grant = last_grant_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= PORT_B;
      end else if (state_q == ST_IDLE && |eligible) begin
         last_grant_q <= grant;
      end
   end
`endif

   mem_arb_rr u_rr (
      .eligible  (eligible),
      .last_grant(last_grant),
      .grant     (grant)
   );

   assign done    = (state_q == ST_XFER1) || (state_q == ST_XFER0 && !word_q);
   assign rd_word = (state_q == ST_XFER1) ? {bus.mem_dout, rd_lo_q} : {8'h00, bus.mem_dout};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         grant_q   <= PORT_A;
         we_q      <= 1'b0;
         word_q    <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_lo_q   <= '0;
         a_ack_q   <= 1'b0;
         b_ack_q   <= 1'b0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         a_ack_q <= 1'b0;
         b_ack_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (|eligible) begin
                  grant_q <= grant;
                  we_q    <= (grant == PORT_B) ? bus.b_we    : bus.a_we;
                  word_q  <= (grant == PORT_B) ? bus.b_word  : bus.a_word;
                  addr_q  <= (grant == PORT_B) ? bus.b_addr  : bus.a_addr;
                  wdata_q <= (grant == PORT_B) ? bus.b_wdata : bus.a_wdata;
                  state_q <= ST_XFER0;
               end
            end
            ST_XFER0: begin
               if (word_q) begin
                  rd_lo_q <= bus.mem_dout;
                  state_q <= ST_XFER1;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_XFER1: state_q <= ST_IDLE;
            default:  state_q <= ST_IDLE;
         endcase
         // Port rdata only changes when a read completes, so it holds between reads.
         if (done) begin
            if (grant_q == PORT_A) begin
               a_ack_q <= 1'b1;
               if (!we_q) a_rdata_q <= rd_word;
            end else begin
               b_ack_q <= 1'b1;
               if (!we_q) b_rdata_q <= rd_word;
            end
         end
      end
   end

   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_din;
   logic              mem_read, mem_write;

   always_comb begin
      mem_addr  = '0;
      mem_din   = '0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      unique case (state_q)
         ST_XFER0: begin
            mem_addr  = addr_q;
            mem_din   = we_q ? lane_byte(wdata_q, LO_LANE) : 8'h00;
            mem_write = we_q;
            mem_read  = !we_q;
         end
         ST_XFER1: begin
            mem_addr  = addr_q + ADDR_W'(1);
            mem_din   = we_q ? lane_byte(wdata_q, HI_LANE) : 8'h00;
            mem_write = we_q;
            mem_read  = !we_q;
         end
         default: ;
      endcase
   end

   assign bus.mem_addr  = mem_addr;
   assign bus.mem_din   = mem_din;
   assign bus.mem_read  = mem_read;
   assign bus.mem_write = mem_write;
   assign bus.a_ack     = a_ack_q;
   assign bus.b_ack     = b_ack_q;
   assign bus.a_rdata   = a_rdata_q;
   assign bus.b_rdata   = b_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a byte-wide memory model.
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_arb_if #(.ADDR_W(16)) bus ();

   mem_arbiter #(.ADDR_W(16)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   logic [7:0]  mem [0:65535];
   logic        poke_en = 1'b0;
   logic [15:0] poke_addr = '0;
   logic [7:0]  poke_data = '0;
   logic [15:0] wa [0:255];
   logic [7:0]  wd [0:255];
   int          wr_cnt = 0;
   int          both_cnt = 0;

   assign bus.mem_dout = mem[bus.mem_addr];

   always @(posedge clk) begin
      if (poke_en) begin
         mem[poke_addr] <= poke_data;
      end else if (bus.mem_write) begin
         mem[bus.mem_addr] <= bus.mem_din;
         wa[wr_cnt[7:0]] <= bus.mem_addr;
         wd[wr_cnt[7:0]] <= bus.mem_din;
         wr_cnt <= wr_cnt + 1;
      end
   end

   always @(negedge clk) if (bus.mem_read && bus.mem_write) both_cnt <= both_cnt + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [15:0] addr, input logic [7:0] data);
      poke_en = 1'b1; poke_addr = addr; poke_data = data;
      @(posedge clk); #1;
      poke_en = 1'b0;
   endtask

   // Starts #1 after a posedge; returns #1 after the posedge following the ack cycle.
   task automatic xfer(input bit port, input bit we, input bit word, input logic [15:0] addr,
                       input logic [15:0] wdata, output logic [15:0] rdata, output int lat);
      logic ack;
      if (port) begin
         bus.b_we = we; bus.b_word = word; bus.b_addr = addr; bus.b_wdata = wdata; bus.b_req = 1;
      end else begin
         bus.a_we = we; bus.a_word = word; bus.a_addr = addr; bus.a_wdata = wdata; bus.a_req = 1;
      end
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         ack = port ? bus.b_ack : bus.a_ack;
      end while (!ack && lat < 20);
      rdata = port ? bus.b_rdata : bus.a_rdata;
      if (port) bus.b_req = 0; else bus.a_req = 0;
      @(posedge clk); #1;
   endtask

   logic [15:0] rd;
   int          lat;
   int          w0;
   int          nack;
   int          cyc;
   int          last_cyc;

   initial begin
      bus.a_req = 0; bus.a_we = 0; bus.a_word = 0; bus.a_addr = '0; bus.a_wdata = '0;
      bus.b_req = 0; bus.b_we = 0; bus.b_word = 0; bus.b_addr = '0; bus.b_wdata = '0;
      #1;
      chk("reset_outs", {bus.a_ack, bus.b_ack, bus.a_rdata, bus.b_rdata, bus.mem_read,
                         bus.mem_write, bus.mem_addr, bus.mem_din}, 64'h0);
      poke(16'h0300, 8'h11);
      poke(16'h0301, 8'h77);
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;

      // Byte write then read on A
      w0 = wr_cnt;
      xfer(0, 1, 0, 16'h0100, 16'h005A, rd, lat);
      chk("bw_lat", lat, 2);
      chk("bw_nwr", wr_cnt - w0, 1);
      chk("bw_wr", {wa[w0[7:0]], wd[w0[7:0]]}, {16'h0100, 8'h5A});
      xfer(0, 0, 0, 16'h0100, 16'h0000, rd, lat);
      chk("br_lat", lat, 2);
      chk("br_data", rd, 16'h005A);

      // Word write then read on B
      w0 = wr_cnt;
      xfer(1, 1, 1, 16'h2000, 16'hBEEF, rd, lat);
      chk("ww_lat", lat, 3);
      chk("ww_nwr", wr_cnt - w0, 2);
      chk("ww_wr", {wa[w0[7:0]], wd[w0[7:0]], wa[8'(w0 + 1)], wd[8'(w0 + 1)]},
          {16'h2000, 8'hEF, 16'h2001, 8'hBE});
      xfer(1, 0, 1, 16'h2000, 16'h0000, rd, lat);
      chk("wr_lat", lat, 3);
      chk("wr_data", rd, 16'hBEEF);
      chk("a_rdata_hold", bus.a_rdata, 16'h005A);

      // Address wrap
      w0 = wr_cnt;
      xfer(0, 1, 1, 16'hFFFF, 16'h1234, rd, lat);
      chk("wrap_wr", {wa[w0[7:0]], wd[w0[7:0]], wa[8'(w0 + 1)], wd[8'(w0 + 1)]},
          {16'hFFFF, 8'h34, 16'h0000, 8'h12});
      xfer(0, 0, 1, 16'hFFFF, 16'h0000, rd, lat);
      chk("wrap_rd", rd, 16'h1234);

      // Byte read zero-extends; B last so A wins the next tie
      xfer(1, 0, 0, 16'h2001, 16'h0000, rd, lat);
      chk("zext_rd", rd, 16'h00BE);

      // Contention: both ports hold word reads
      bus.a_we = 0; bus.a_word = 1; bus.a_addr = 16'h2000;
      bus.b_we = 0; bus.b_word = 1; bus.b_addr = 16'hFFFF;
      bus.a_req = 1; bus.b_req = 1;
      nack = 0; cyc = 0; last_cyc = 0;
      while (nack < 6 && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         if (bus.a_ack || bus.b_ack) begin
            chk("cont_port", {bus.a_ack, bus.b_ack}, (nack % 2 == 1) ? 2'b01 : 2'b10);
            chk("cont_rdata", bus.a_ack ? bus.a_rdata : bus.b_rdata,
                (nack % 2 == 1) ? 16'h1234 : 16'hBEEF);
            chk("cont_gap", cyc - last_cyc, 3);
            if (nack == 5) begin
               bus.a_req = 0; bus.b_req = 0;
            end
            nack++;
            last_cyc = cyc;
         end
      end
      chk("cont_count", nack, 6);
      repeat (4) @(posedge clk);
      #1;
      chk("no_both_strobes", both_cnt, 0);

      // Reset during XFER1 of a word write
      bus.a_we = 1; bus.a_word = 1; bus.a_addr = 16'h0300; bus.a_wdata = 16'hABCD; bus.a_req = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_xfer1_addr", {bus.mem_write, bus.mem_addr}, {1'b1, 16'h0301});
      rst_n = 0;
      #1;
      chk("mid_reset_outs", {bus.a_ack, bus.b_ack, bus.a_rdata, bus.b_rdata, bus.mem_read,
                             bus.mem_write, bus.mem_addr, bus.mem_din}, 64'h0);
      bus.a_req = 0;
      @(posedge clk); #1;
      rst_n = 1;
      chk("partial_lo", mem[16'h0300], 8'hCD);
      chk("partial_hi", mem[16'h0301], 8'h77);

      // First tie after reset goes to A
      bus.a_we = 0; bus.a_word = 0; bus.a_addr = 16'h0300;
      bus.b_we = 0; bus.b_word = 0; bus.b_addr = 16'h0301;
      bus.a_req = 1; bus.b_req = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("post_rst_tie", {bus.a_ack, bus.b_ack, bus.a_rdata}, {2'b10, 16'h00CD});
      bus.a_req = 0;
      cyc = 0;
      while (!bus.b_ack && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("post_rst_b", {bus.b_ack, bus.b_rdata, 8'(cyc)}, {1'b1, 16'h0077, 8'd2});
      bus.b_req = 0;
      repeat (2) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and two-port arbiter in front of the byte-wide 64 KiB main memory. It shares the single memory port between the CPU (port A) and a DMA/loader master (port B). It also splits 16-bit word accesses into two little-endian byte cycles. Every transaction is atomic; the memory itself is untouched: combinational read, write on the clock edge.

## Interface
Parameters:
- ADDR_W, 16, address width for both requesters and memory.

Ports:
- clk  in  1  system clock; all state changes on posedge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- a_req, b_req  in  1  transaction request; held with its fields stable until the matching ack
- a_we, b_we  in  1  1 = write, 0 = read
- a_word, b_word  in  1  1 = 16-bit access, 0 = byte access
- a_addr, b_addr  in  ADDR_W  byte address; a word occupies addr and addr+1
- a_wdata, b_wdata  in  16  write data; byte access uses [7:0]
- a_ack, b_ack  out  1  one-cycle completion pulse
- a_rdata, b_rdata  out  16  read data, valid while ack is high; byte read zero-extends
- mem_addr  out  ADDR_W  memory address
- mem_din  out  8  memory write data
- mem_read, mem_write  out  1  memory strobes
- mem_dout  in  8  memory read data, combinational from mem_addr

## Operation
- State machine: IDLE, XFER0 (low byte at addr), XFER1 (high byte at addr+1).
- **IDLE:**
  - A request is eligible if its req is high and its own ack is not high this cycle. The ack-cycle mask prevents a double grant.
  - Only one eligible port: grant it.
  - Both eligible: grant the port not granted last (round-robin).
  - At the grant edge, latch we, word, addr and wdata into internal registers, record the grant, and go to XFER0.
- **XFER0:**
  - Drive mem_addr = latched addr.
  - For a write, mem_din = wdata[7:0] and mem_write = 1. For a read, mem_read = 1 and rdata[7:0] is captured at the edge.
  - Word access: go to XFER1. Byte access: pulse ack and return to IDLE.
- **XFER1:**
  - Drive mem_addr = addr+1, modulo 2^ADDR_W; 16'hFFFF wraps to 16'h0000.
  - Use wdata[15:8] for a write; capture rdata[15:8] for a read.
  - Pulse ack and return to IDLE.
- Memory strobes are decoded from registered state. Both strobes are 0 in IDLE, and mem_read and mem_write are never high together.
- The rdata register is held until the next read completes on that port.
- **Reset**, including mid-transaction: state goes to IDLE and the last-grant pointer resets so that A wins the first tie. The following are all 0:
  - a_ack, b_ack, a_rdata, b_rdata
  - mem_read, mem_write, mem_addr, mem_din
- A reset in XFER1 of a word write leaves the low byte written and the high byte unwritten. This partial write is accepted behaviour.

## Timing
- **Latency:**
  - Byte access: ack is high in the 2nd cycle after the req-sampling edge.
  - Word access: ack is high in the 3rd cycle.
- **Back-to-back:**
  - Another port can be granted in the same cycle an ack is high.
  - The same port re-requesting incurs one ack cycle of gap.
- **Sustained contention:** A and B alternate strictly. No port waits longer than one full transaction (worst case 3 cycles) beyond its own.
- **Request changes:** a req dropped before grant is simply not served. Field changes after the grant edge are ignored.

## Configuration
- MEM_ARB_FIXED_PRIORITY_EN:
  - Defined: port A always wins a tie, and the last-grant pointer is not built. B can starve under continuous A traffic.
  - Undefined (default): round-robin as described above.

## Structure
- Shared package mem_arb_pkg holds:
  - state encodings ST_IDLE, ST_XFER0, ST_XFER1
  - port IDs PORT_A, PORT_B
  - byte-lane constants LO_LANE, HI_LANE
- Sub-module mem_arb_rr: combinational 2-way picker with inputs eligible[1:0] and last_grant, output grant. The fixed-priority macro is honoured inside it.

## Test plan
- **Byte write then read:** A writes 8'h5A to 16'h0100, then reads it back. Required: a_ack one cycle each, a_rdata = 16'h005A, one mem_write pulse with mem_addr = 16'h0100.
- **Word write then read:** B writes 16'hBEEF to 16'h2000. Required: mem writes EF@2000 then BE@2001; a word read returns b_rdata = 16'hBEEF with ack in the 3rd cycle.
- **Address wrap:** word write of 16'h1234 to 16'hFFFF. Required: 34@FFFF, 12@0000.
- **Contention:** A and B request word reads together for 6 transactions. Required: grants A, B, A, B, A, B, and no cycle with both strobes high.
  - With MEM_ARB_FIXED_PRIORITY_EN defined, B is starved until A drops req.
- **Mid-transaction reset:** rst_n low during XFER1 of a word write to 16'h0300. Required: all outputs 0 immediately, 16'h0300 written, 16'h0301 unchanged, first post-reset tie granted to A.
